glove_tx_scheduler: RTL

//   Shares the single glove-to-master UART byte transmitter between NUM_REQ command sources.

---
 rtl/glove_tx_scheduler.sv | 87 ++++++++
 1 files changed

// File: rtl/glove_tx_scheduler.sv
// glove_tx_scheduler: round-robin arbitration of command sources into a FIFO,
// drained to the shared UART transmitter under RTS flow control.
module glove_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      flush,
  input  logic                      master_rts,
  input  logic                      uart_ready,
  output logic                      uart_send,
  output logic [DATA_W-1:0]         uart_data,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [15:0]               sent_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, LAUNCH, GUARD} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0] count_q, count_d;
  logic [RW-1:0] rr_q, rr_d, g;
  logic [DATA_W-1:0] data_q, data_d;
  logic [15:0] sent_q, sent_d;
  logic [DATA_W-1:0] buffer_q [DEPTH];
  logic push, pop, found;
  int idx;
  always_comb begin
    grant = '0;
    g = rr_q;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        g = RW'(idx);
      end
    end
    if (found && rst && !flush && count_q < (AW+1)'(DEPTH)) grant[g] = 1'b1;
  end
  assign push = |grant;
  assign pop  = state_q == LAUNCH;
  always_comb begin
    state_d = state_q == IDLE
            ? ((count_q != '0 && uart_ready && !master_rts && !flush) ? LAUNCH : IDLE)
            : (state_q == LAUNCH ? GUARD : IDLE);
    data_d  = (state_q == IDLE && state_d == LAUNCH) ? buffer_q[head_q] : data_q;
    // a flush during LAUNCH absorbs the pop: head jumps straight to tail
    head_d  = flush ? tail_q : head_q + AW'(pop);
    tail_d  = tail_q + AW'(push);
    count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    rr_d    = push ? RW'((int'(g) + 1) % NUM_REQ) : rr_q;
    sent_d  = (pop && sent_q != 16'hFFFF) ? sent_q + 16'd1 : sent_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rr_q    <= '0;
      data_q  <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      sent_q  <= sent_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) buffer_q[tail_q] <= req_data[g*DATA_W +: DATA_W];
  end
  assign uart_send  = pop;
  assign uart_data  = data_q;
  assign fifo_count = count_q;
  assign sent_cnt   = sent_q;
endmodule
